fetch_unit: RTL

Parametrised instruction-fetch front end for the pipelined successor of the single-cycle core. It owns the PC register and issues in-order requests to an instruction memory with variable latency. Returned words are buffered in a small reservation queue and presented to decode via a valid/ready handshake. Later stages redirect fetch on a taken branch or jump; wrong-path entries and in-flight responses are discarded.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 90 +++++++++
 rtl/fetch_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, entry type and sizing helper for the fetch front end.
//   RESET_PC_DEFAULT    - PC after reset when the top is left at its defaults
//   INSTR_BYTES_DEFAULT - sequential PC increment
//   fetch_entry_t       - one reservation-queue slot {pc, instr, filled}
//   ptr_w()             - pointer width for a queue of a given depth
package fetch_pkg;

  localparam int unsigned XLEN_DEF            = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES_DEFAULT = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
    logic                filled;
  } fetch_entry_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular reservation queue between instruction memory and decode.
//   clk, rst_n      - clock, async active-low reset
//   flush           - clears every entry and pointer (wins over all other ops)
//   alloc, alloc_pc - reserve the tail entry for a request issued to address alloc_pc
//   fill, fill_data - write the oldest unfilled entry (ignored when none is pending)
//   pop             - retire the head entry
//   head_valid      - head entry exists and is filled
//   head_pc/instr   - head entry contents (zero while head_valid is low)
//   full, empty     - occupancy flags
//   unfilled        - number of allocated entries still waiting for data
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned QDEPTH = 4,
  localparam int unsigned PW    = ptr_w(QDEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr,
  output logic            full,
  output logic            empty,
  output logic [PW:0]     unfilled
);

  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0]   pc_mem    [QDEPTH];
  logic [XLEN-1:0]   instr_mem [QDEPTH];
  logic [QDEPTH-1:0] filled;
  logic [PW-1:0]     head, tail, fptr;
  logic [CW-1:0]     count, pend;
  logic              do_fill;

  // A fill with nothing outstanding is a protocol violation and is dropped.
  assign do_fill    = fill && (pend != '0);
  assign full       = (count == CW'(QDEPTH));
  assign empty      = (count == '0);
  assign unfilled   = pend;
  assign head_valid = !empty && filled[head];
  assign head_pc    = head_valid ? pc_mem[head]    : '0;
  assign head_instr = head_valid ? instr_mem[head] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      fptr   <= '0;
      count  <= '0;
      pend   <= '0;
      filled <= '0;
    end else if (flush) begin
      head   <= '0;
      tail   <= '0;
      fptr   <= '0;
      count  <= '0;
      pend   <= '0;
      filled <= '0;
    end else begin
      // alloc (tail) and fill (fptr) never hit the same slot: when pend==0
      // no fill happens, otherwise fptr trails tail.
      if (alloc) begin
        tail         <= tail + PW'(1);
        filled[tail] <= 1'b0;
      end
      if (do_fill) begin
        fptr         <= fptr + PW'(1);
        filled[fptr] <= 1'b1;
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(alloc) - CW'(pop);
      pend  <= pend + CW'(alloc) - CW'(do_fill);
    end
  end

  // Payload storage needs no reset; outputs are masked by head_valid.
  always_ff @(posedge clk) begin
    if (alloc && !flush)   pc_mem[tail]    <= alloc_pc;
    if (do_fill && !flush) instr_mem[fptr] <= fill_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the PC, issues in-order requests
// to a variable-latency instruction memory, buffers returned words and hands
// them to decode; a redirect flushes the queue and discards in-flight responses.
//   clk, rst_n                        - clock, async active-low reset
//   imem_req_valid/ready/addr         - request channel to instruction memory
//   imem_rsp_valid/data               - in-order response channel
//   redirect_valid/pc                 - taken branch / jump from a later stage
//   id_valid/ready/instr/pc/pc_plus4  - handshake to decode
//   busy                              - queue non-empty or responses still to discard
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned     QDEPTH      = 4,
  parameter int unsigned     INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            busy
);

  localparam int unsigned PW = ptr_w(QDEPTH);
  // Back-to-back redirects can stack discards beyond one queue's worth while
  // the memory is slow, so the drop counter gets extra headroom.
  localparam int unsigned DW = PW + 4;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redir_target;
  logic [DW-1:0]   drop_cnt, drop_nxt, drop_sum;
  logic            q_full, q_empty, head_valid;
  logic [PW:0]     unfilled;
  logic [XLEN-1:0] head_pc, head_instr;
  logic            accept, rsp_drop, rsp_fill, pop;

  assign redir_target = redirect_pc & ~XLEN'(3);

  // Gated by rst_n so every output except the address reads zero in reset.
  assign imem_req_valid = rst_n && !redirect_valid && !q_full;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign id_valid    = head_valid && !redirect_valid;
  assign pop         = id_valid && id_ready;
  assign id_instr    = id_valid ? head_instr : '0;
  assign id_pc       = id_valid ? head_pc : '0;
  assign id_pc_plus4 = id_valid ? head_pc + XLEN'(INSTR_BYTES) : '0;

  assign busy = !q_empty || (drop_cnt != '0);

  // On redirect every still-unfilled entry becomes a response to discard;
  // a response landing in the redirect cycle is consumed right away.
  always_comb begin
    drop_sum = drop_cnt + DW'(unfilled);
    drop_nxt = drop_cnt;
    if (redirect_valid) begin
      drop_nxt = (imem_rsp_valid && (drop_sum != '0)) ? drop_sum - DW'(1) : drop_sum;
    end else if (rsp_drop) begin
      drop_nxt = drop_cnt - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_nxt;
      if (redirect_valid) pc_q <= redir_target;
      else if (accept)    pc_q <= pc_q + XLEN'(INSTR_BYTES);
    end
  end

  fetch_queue #(
    .XLEN   (XLEN),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .alloc      (accept),
    .alloc_pc   (pc_q),
    .fill       (rsp_fill),
    .fill_data  (imem_rsp_data),
    .pop        (pop),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .full       (q_full),
    .empty      (q_empty),
    .unfilled   (unfilled)
  );

endmodule
